// File: rtl/fios_dsp_seq_if.sv
// Handshake and memory/DSP control bundle between a sweep requester and the FIOS DSP sequencer.
// AW must equal $clog2(WORD_COUNT) of the attached sequencer.
interface fios_dsp_seq_if #(
  parameter int AW = 3
);
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] a_addr_o;
  logic [AW-1:0] b_addr_o;
  logic [AW-1:0] c_addr_o;
  logic          CREG_en_o;
  logic [6:0]    OPMODE_o;
  logic          res_we_o;
  logic [AW-1:0] res_addr_o;

  modport master (
    output start_i,
    input  busy_o, done_o, a_addr_o, b_addr_o, c_addr_o,
    input  CREG_en_o, OPMODE_o, res_we_o, res_addr_o
  );

  modport slave (
    input  start_i,
    output busy_o, done_o, a_addr_o, b_addr_o, c_addr_o,
    output CREG_en_o, OPMODE_o, res_we_o, res_addr_o
  );
endinterface

// File: rtl/fios_dsp_seq.sv
// Issues an S x S limb-product sweep to a pipelined DSP slice and times the C-input,
// OPMODE and result-write controls against the DSP's register depth.
module fios_dsp_seq #(
  parameter int WORD_COUNT = 8,
  parameter int ABREG      = 1,
  parameter int MREG       = 1
) (
  input logic           clock_i,
  input logic           reset_n_i,
  fios_dsp_seq_if.slave bus
);
  localparam int D  = 1 + ABREG + MREG;
  localparam int L  = ABREG + MREG;          // issue-to-OPMODE latency
  localparam int AW = $clog2(WORD_COUNT);

  localparam logic [6:0] OP_M  = 7'h05;      // P = M
  localparam logic [6:0] OP_MP = 7'h65;      // P = M + (P >> 17)
  localparam logic [6:0] OP_MC = 7'h35;      // P = M + C

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // One issued product travelling down the control pipeline; all fields are zero for a bubble.
  typedef struct packed {
    logic          valid;
    logic          use_c;
    logic [AW-1:0] j;
    logic [6:0]    op;
  } slot_t;

  state_t        state_q;
  logic [AW-1:0] i_q, j_q;
  logic [2:0]    drain_q;
  logic          busy_q, done_q;

  slot_t cur;
  slot_t sr_q [1:D+1];
  slot_t tap  [0:D+1];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cur = '0;
    if (state_q == ISSUE) begin
      cur.valid = 1'b1;
      cur.use_c = (i_q != '0);
      cur.j     = j_q;
      if (i_q != '0)      cur.op = OP_MC;
      else if (j_q != '0) cur.op = OP_MP;
      else                cur.op = OP_M;
    end
  end

  always_comb begin
    tap[0] = cur;
    for (int k = 1; k <= D + 1; k++) tap[k] = sr_q[k];
  end

  // NOTE: the delay line is control state, not storage, so it is cleared on reset; a reset
  // mid-sweep must not let stale write enables leak out afterwards.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 1; k <= D + 1; k++) sr_q[k] <= '0;
    end else begin
      sr_q[1] <= cur;
      for (int k = 2; k <= D + 1; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (j_q == AW'(WORD_COUNT - 1)) begin
            j_q <= '0;
            if (i_q == AW'(WORD_COUNT - 1)) begin
              i_q     <= '0;
              drain_q <= '0;
              state_q <= DRAIN;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        DRAIN: begin
          // Covers the D+1 cycles until the last product's write enable has left.
          if (drain_q == 3'(D)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.a_addr_o   = j_q;
  assign bus.b_addr_o   = i_q;
  assign bus.OPMODE_o   = tap[L].op;
  assign bus.CREG_en_o  = tap[L-1].use_c;
  assign bus.c_addr_o   = tap[L-1].use_c ? tap[L-1].j : '0;
  assign bus.res_we_o   = tap[D+1].valid;
  assign bus.res_addr_o = tap[D+1].j;
endmodule

// File: tb/tb_fios_dsp_seq.sv
// Directed bench for fios_dsp_seq: S=4/D=3 and S=2/ABREG=0 instances, cycle-exact checks.
module tb_fios_dsp_seq;
  logic clock_i = 1'b0;
  logic reset_n_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock_i = ~clock_i;

  fios_dsp_seq_if #(.AW(2)) if0 ();
  fios_dsp_seq_if #(.AW(1)) if1 ();

  fios_dsp_seq #(.WORD_COUNT(4), .ABREG(1), .MREG(1)) dut0 (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .bus       (if0)
  );

  fios_dsp_seq #(.WORD_COUNT(2), .ABREG(0), .MREG(1)) dut1 (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .bus       (if1)
  );

  logic [6:0] op_tab [16] = '{7'h05, 7'h65, 7'h65, 7'h65,
                              7'h35, 7'h35, 7'h35, 7'h35,
                              7'h35, 7'h35, 7'h35, 7'h35,
                              7'h35, 7'h35, 7'h35, 7'h35};

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs at offset k from the first issue cycle (k<0 or past done: idle).
  task automatic check_cycle(input int sel, input int s, input int lat, input int d,
                             input int k, input string where);
    int n;
    int busy_e, done_e, a_e, b_e, op_e, creg_e, c_e, we_e, ra_e;
    int busy, done, a, b, op, creg, c, we, ra;
    busy_e = (k >= 0 && k < s*s + d + 1) ? 1 : 0;
    done_e = (k == s*s + d + 1) ? 1 : 0;
    a_e = 0; b_e = 0; op_e = 0; creg_e = 0; c_e = 0; we_e = 0; ra_e = 0;
    n = k;
    if (n >= 0 && n < s*s) begin a_e = n % s; b_e = n / s; end
    n = k - lat;
    if (n >= 0 && n < s*s) op_e = (n == 0) ? 'h05 : (n < s) ? 'h65 : 'h35;
    n = k - (lat - 1);
    if (n >= s && n < s*s) begin creg_e = 1; c_e = n % s; end
    n = k - (d + 1);
    if (n >= 0 && n < s*s) begin we_e = 1; ra_e = n % s; end
    if (sel == 0) begin
      busy = if0.busy_o; done = if0.done_o; a = if0.a_addr_o; b = if0.b_addr_o;
      op = if0.OPMODE_o; creg = if0.CREG_en_o; c = if0.c_addr_o;
      we = if0.res_we_o; ra = if0.res_addr_o;
    end else begin
      busy = if1.busy_o; done = if1.done_o; a = if1.a_addr_o; b = if1.b_addr_o;
      op = if1.OPMODE_o; creg = if1.CREG_en_o; c = if1.c_addr_o;
      we = if1.res_we_o; ra = if1.res_addr_o;
    end
    check({where, " busy"}, busy, busy_e);
    check({where, " done"}, done, done_e);
    check({where, " a_addr"}, a, a_e);
    check({where, " b_addr"}, b, b_e);
    check({where, " opmode"}, op, op_e);
    check({where, " creg_en"}, creg, creg_e);
    check({where, " c_addr"}, c, c_e);
    check({where, " res_we"}, we, we_e);
    check({where, " res_addr"}, ra, ra_e);
  endtask

  initial begin
    if0.start_i = 1'b0;
    if1.start_i = 1'b0;

    // Reset state
    #2;
    check_cycle(0, 4, 2, 3, -1, "rst dut0");
    check_cycle(1, 2, 1, 2, -1, "rst dut1");
    @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clock_i);

    // Nominal S=4, D=3 sweep; start sampled at edge 0
    if0.start_i = 1'b1;
    @(posedge clock_i);
    #1 if0.start_i = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clock_i);
      check_cycle(0, 4, 2, 3, cyc - 1, $sformatf("nom c%0d", cyc));
      if (cyc >= 3 && cyc <= 18) check($sformatf("optab c%0d", cyc), int'(if0.OPMODE_o), int'(op_tab[cyc-3]));
    end

    // start held high: second sweep issues from cycle 23
    if0.start_i = 1'b1;
    @(posedge clock_i);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clock_i);
      check_cycle(0, 4, 2, 3, (cyc < 23) ? cyc - 1 : cyc - 23, $sformatf("hold c%0d", cyc));
      if (cyc == 30) if0.start_i = 1'b0;
    end

    // Reset pulse in issue cycle 8
    if0.start_i = 1'b1;
    @(posedge clock_i);
    #1 if0.start_i = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock_i);
      check_cycle(0, 4, 2, 3, cyc - 1, $sformatf("pre-rst c%0d", cyc));
    end
    #1 reset_n_i = 1'b0;
    #1 check_cycle(0, 4, 2, 3, -1, "in-rst");
    @(negedge clock_i);
    check_cycle(0, 4, 2, 3, -1, "in-rst c9");
    #1 reset_n_i = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clock_i);
      check_cycle(0, 4, 2, 3, -1, $sformatf("post-rst c%0d", cyc));
    end
    if0.start_i = 1'b1;
    @(posedge clock_i);
    #1 if0.start_i = 1'b0;
    for (int cyc = 1; cyc <= 23; cyc++) begin
      @(negedge clock_i);
      check_cycle(0, 4, 2, 3, cyc - 1, $sformatf("restart c%0d", cyc));
    end

    // ABREG=0, MREG=1, S=2: done in cycle 8
    if1.start_i = 1'b1;
    @(posedge clock_i);
    #1 if1.start_i = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock_i);
      check_cycle(1, 2, 1, 2, cyc - 1, $sformatf("s2 c%0d", cyc));
      if (cyc == 8) check("s2 done c8", int'(if1.done_o), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
